// File: rtl/refill_writer.sv
// Cache line refill writer: streams memory beats into the data BRAM and bypasses the missed word.
// Optional build macro REFILL_CRITICAL_WORD_FIRST_EN starts the fill at the missed word offset.
module refill_writer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int OFFSET_WIDTH = 2,
    localparam int IW          = ADDR_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [IW-1:0]           req_index,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic                    mem_last,
    output logic                    bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_waddr,
    output logic [DATA_WIDTH-1:0]   bram_din,
    output logic                    crit_valid,
    output logic [DATA_WIDTH-1:0]   crit_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [IW-1:0]           index_r;
    logic [OFFSET_WIDTH-1:0] cur_off_r;
    logic [OFFSET_WIDTH-1:0] crit_off_r;
    logic [OFFSET_WIDTH-1:0] beat_cnt_r;
    logic                    last_err_r;
    logic                    bram_we_r;
    logic [ADDR_WIDTH-1:0]   bram_waddr_r;
    logic [DATA_WIDTH-1:0]   bram_din_r;
    logic                    crit_valid_r;
    logic [DATA_WIDTH-1:0]   crit_data_r;
    logic                    done_r;
    logic                    err_r;

    logic [OFFSET_WIDTH-1:0] start_off_s;
    logic                    final_beat_s;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign start_off_s = req_offset;
`else
    assign start_off_s = {OFFSET_WIDTH{1'b0}};
`endif

    // Termination counts beats only; mem_last is merely cross-checked.
    assign final_beat_s = (beat_cnt_r == {OFFSET_WIDTH{1'b1}});

    // Refill FSM with registered write port, bypass and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            index_r      <= {IW{1'b0}};
            cur_off_r    <= {OFFSET_WIDTH{1'b0}};
            crit_off_r   <= {OFFSET_WIDTH{1'b0}};
            beat_cnt_r   <= {OFFSET_WIDTH{1'b0}};
            last_err_r   <= 1'b0;
            bram_we_r    <= 1'b0;
            bram_waddr_r <= {ADDR_WIDTH{1'b0}};
            bram_din_r   <= {DATA_WIDTH{1'b0}};
            crit_valid_r <= 1'b0;
            crit_data_r  <= {DATA_WIDTH{1'b0}};
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            bram_we_r    <= 1'b0;
            crit_valid_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        index_r    <= req_index;
                        crit_off_r <= req_offset;
                        cur_off_r  <= start_off_s;
                        beat_cnt_r <= {OFFSET_WIDTH{1'b0}};
                        last_err_r <= 1'b0;
                        state_r    <= S_FILL;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (mem_valid) begin
                        bram_we_r    <= 1'b1;
                        bram_waddr_r <= {index_r, cur_off_r};
                        bram_din_r   <= mem_data;
                        if (cur_off_r == crit_off_r) begin
                            crit_valid_r <= 1'b1;
                            crit_data_r  <= mem_data;
                        end else begin
                            crit_valid_r <= 1'b0;
                        end
                        cur_off_r  <= cur_off_r + OFFSET_WIDTH'(1);
                        beat_cnt_r <= beat_cnt_r + OFFSET_WIDTH'(1);
                        if (final_beat_s) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                            err_r   <= last_err_r | ~mem_last;
                        end else begin
                            // An early mem_last is remembered and reported with done.
                            last_err_r <= last_err_r | mem_last;
                        end
                    end else begin
                        state_r <= S_FILL;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_r == S_IDLE);
    assign mem_ready  = (state_r == S_FILL);
    assign busy       = (state_r != S_IDLE);
    assign bram_we    = bram_we_r;
    assign bram_waddr = bram_waddr_r;
    assign bram_din   = bram_din_r;
    assign crit_valid = crit_valid_r;
    assign crit_data  = crit_data_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule
